id_ex_stage: RTL

- ID/EX pipeline boundary of the 5-stage MIPS-subset core; sits directly downstream of the control decoder and register file.
- Latches the decoded control bundle, operands, immediate and register specifiers into EX.
- Contains load-use hazard detection: inserts one bubble and holds PC/IF-ID.
- Squashes on branch/jump redirect.

---
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and redirect squash.
// Optional hazard counters (stall_cnt, flush_cnt) are enabled by defining IDEX_HAZARD_STATS_EN.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_RegWrite,
    input  logic          id_MemToReg,
    input  logic          id_MemWrite,
    input  logic          id_BranchEq,
    input  logic          id_Jump,
    input  logic          id_ALUSrc,
    input  logic          id_RegDst,
    input  logic [2:0]    id_ALUc,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic          flush,
    output logic          ex_valid,
    output logic          ex_RegWrite,
    output logic          ex_MemToReg,
    output logic          ex_MemWrite,
    output logic          ex_BranchEq,
    output logic          ex_Jump,
    output logic          ex_ALUSrc,
    output logic [2:0]    ex_ALUc,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_wreg,
`ifdef IDEX_HAZARD_STATS_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt,
`endif
    output logic          stall
);

    typedef struct packed {
        logic       RegWrite;
        logic       MemToReg;
        logic       MemWrite;
        logic       BranchEq;
        logic       Jump;
        logic       ALUSrc;
        logic [2:0] ALUc;
    } ctrl_t;

    logic          valid_q, valid_d;
    ctrl_t         ctrl_q, ctrl_d, id_ctrl;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] pc4_q, pc4_d;
    logic [RW-1:0] rs_q, rs_d;
    logic [RW-1:0] rt_q, rt_d;
    logic [RW-1:0] wreg_q, wreg_d;

    logic uses_rs, uses_rt, load_use;

    always_comb begin
        uses_rs  = id_valid & ~id_Jump;
        uses_rt  = id_valid & (~id_RegDst | id_BranchEq | id_MemWrite);
        load_use = valid_q & ctrl_q.MemToReg & (wreg_q != '0)
                 & ((uses_rs & (wreg_q == id_rs)) | (uses_rt & (wreg_q == id_rt)));
    end

    assign stall = load_use & ~flush & ~rst;

    always_comb begin
        id_ctrl = '{RegWrite: id_RegWrite, MemToReg: id_MemToReg, MemWrite: id_MemWrite,
                    BranchEq: id_BranchEq, Jump: id_Jump, ALUSrc: id_ALUSrc, ALUc: id_ALUc};
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc4_d     = pc4_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        wreg_d    = wreg_q;
        // Bubbles clear valid and controls only; data fields keep their old contents.
        if (flush || stall) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d   = id_valid;
            ctrl_d    = id_valid ? id_ctrl : '0;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            pc4_d     = id_pc4;
            rs_d      = id_rs;
            rt_d      = id_rt;
            wreg_d    = id_RegDst ? id_rt : id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            wreg_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc4_q     <= pc4_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            wreg_q    <= wreg_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegWrite = ctrl_q.RegWrite;
    assign ex_MemToReg = ctrl_q.MemToReg;
    assign ex_MemWrite = ctrl_q.MemWrite;
    assign ex_BranchEq = ctrl_q.BranchEq;
    assign ex_Jump     = ctrl_q.Jump;
    assign ex_ALUSrc   = ctrl_q.ALUSrc;
    assign ex_ALUc     = ctrl_q.ALUc;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_pc4      = pc4_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_wreg     = wreg_q;

`ifdef IDEX_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
